// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//   Direct-mapped branch predictor (2-bit BHT + tagged BTB) with a small
//   RUN/REDIRECT controller that turns EX-stage mispredictions into a
//   registered PC redirect plus front-end flush, and keeps branch statistics.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   if_pc                   : fetch PC to look up
//   pred_taken, pred_target : combinational prediction for if_pc
//   ex_valid, ex_pc, ex_target, ex_taken
//                           : conditional branch resolving in EX
//   ex_pred_taken, ex_pred_target
//                           : prediction that branch was fetched with
//   stall                   : pipeline freeze, holds a pending redirect
//   redirect, redirect_pc   : PC override toward the correct path
//   flush                   : flush IF/ID and ID/EX while redirecting
//   branch_cnt, mispred_cnt : saturating statistics counters
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_bht        [DEPTH];
  logic [DEPTH-1:0]    r_btb_valid;
  logic [TAG_W-1:0]    r_btb_tag    [DEPTH];
  logic [31:0]         r_btb_target [DEPTH];

  logic [31:0]         r_redirect_pc;
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic [IDX_W-1:0]    w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic [IDX_W-1:0]    w_ex_idx;
  logic [TAG_W-1:0]    w_ex_tag;
  logic                w_btb_hit;
  logic                w_accept;
  logic                w_mispred;
  logic                w_start_redirect;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[31:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[31:IDX_W+2];

  // Lookup reads the registered tables only, so a same-cycle write is not
  // visible until the following cycle.
  assign w_btb_hit   = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_btb_hit && r_bht[w_if_idx][1];
  assign pred_target = w_btb_hit ? r_btb_target[w_if_idx] : (if_pc + 32'd4);

  // Branches resolving while a redirect is pending are on the wrong path.
  assign w_accept  = ex_valid && (r_state == RUN);
  assign w_mispred = (ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
  assign w_start_redirect = w_accept && w_mispred;

  assign redirect    = (r_state == REDIRECT);
  assign flush       = (r_state == REDIRECT);
  assign redirect_pc = r_redirect_pc;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

  // Controller next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_start_redirect) begin
          w_state_nxt = REDIRECT;
        end else begin
          w_state_nxt = RUN;
        end
      end
      REDIRECT: begin
        if (!stall) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = REDIRECT;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Correct-path PC captured when a mispredict is accepted; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_pc <= 32'd0;
    end else if (w_start_redirect) begin
      r_redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
    end
  end

  // BHT/BTB training on accepted branches; not-taken leaves the BTB alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bht[i]        <= 2'b01;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= 32'd0;
      end
      r_btb_valid <= '0;
    end else if (w_accept) begin
      if (ex_taken) begin
        if (r_bht[w_ex_idx] != 2'b11) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
        end
        r_btb_valid[w_ex_idx]  <= 1'b1;
        r_btb_tag[w_ex_idx]    <= w_ex_tag;
        r_btb_target[w_ex_idx] <= ex_target;
      end else begin
        if (r_bht[w_ex_idx] != 2'b00) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
        end
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_accept && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_start_redirect && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//   Directed scenarios followed by randomized traffic. The stimulus process
//   pushes the expected outputs for each cycle into a queue and advances a
//   behavioural model; a separate monitor pops and compares at the falling
//   edge.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

  localparam int IDX_W = 4;
  localparam int CNT_W = 16;
  localparam int DEPTH = 16;
  localparam int CNT_MAX = 65535;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             ex_taken;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // ---------------- reference model ----------------
  int          m_bht [DEPTH];
  bit          m_v   [DEPTH];
  logic [31:0] m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_bcnt;
  int          m_mcnt;

  typedef struct {
    bit          pt;
    logic [31:0] ptgt;
    bit          redir;
    logic [31:0] rpc;
    int          bcnt;
    int          mcnt;
  } exp_t;
  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_bht[i] = 1; m_v[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0;
    end
    m_redir = 1'b0; m_rpc = 32'd0; m_bcnt = 0; m_mcnt = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit t,
                                        output logic [31:0] g);
    int i;
    i = idx_of(pc);
    if (m_v[i] && (m_tag[i] == tag_of(pc))) begin
      t = (m_bht[i] >= 2);
      g = m_tgt[i];
    end else begin
      t = 1'b0;
      g = pc + 32'd4;
    end
  endfunction

  // Effect of one clock edge given this cycle's EX-stage inputs.
  function automatic void model_edge(input bit v, input logic [31:0] epc,
                                     input bit tk, input logic [31:0] tgt,
                                     input bit ptk, input logic [31:0] ptgt,
                                     input bit st);
    int  i;
    bit  mis;
    if (!m_redir) begin
      if (v) begin
        i = idx_of(epc);
        if (m_bcnt < CNT_MAX) m_bcnt++;
        if (tk) begin
          if (m_bht[i] < 3) m_bht[i]++;
          m_v[i] = 1'b1; m_tag[i] = tag_of(epc); m_tgt[i] = tgt;
        end else begin
          if (m_bht[i] > 0) m_bht[i]--;
        end
        mis = (tk != ptk) || (tk && ptk && (tgt != ptgt));
        if (mis) begin
          if (m_mcnt < CNT_MAX) m_mcnt++;
          m_redir = 1'b1;
          m_rpc   = tk ? tgt : (epc + 32'd4);
        end
      end
    end else if (!st) begin
      m_redir = 1'b0;
    end
  endfunction

  function automatic void push_expected(input logic [31:0] pc);
    exp_t e;
    model_predict(pc, e.pt, e.ptgt);
    e.redir = m_redir;
    e.rpc   = m_rpc;
    e.bcnt  = m_bcnt;
    e.mcnt  = m_mcnt;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
      chk("pred_target", pred_target, e.ptgt);
      chk("redirect",    {31'd0, redirect}, {31'd0, e.redir});
      chk("flush",       {31'd0, flush}, {31'd0, e.redir});
      chk("redirect_pc", redirect_pc, e.rpc);
      chk("branch_cnt",  {16'd0, branch_cnt}, e.bcnt);
      chk("mispred_cnt", {16'd0, mispred_cnt}, e.mcnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [31:0] pc, input bit v, input logic [31:0] epc,
                     input bit tk, input logic [31:0] tgt, input bit ptk,
                     input logic [31:0] ptgt, input bit st);
    if_pc = pc; ex_valid = v; ex_pc = epc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt; stall = st;
    push_expected(pc);
    model_edge(v, epc, tk, tgt, ptk, ptgt, st);
    @(posedge clk); #1;
  endtask

  task automatic reset_cyc(input logic [31:0] pc);
    rst_n = 1'b0; if_pc = pc; ex_valid = 1'b0; stall = 1'b0;
    model_reset();
    push_expected(pc);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] pcs  [8];
  logic [31:0] tgts [4];
  logic [31:0] p, ep, tg, pg;
  bit          v, tk, ptk, st;

  initial begin
    pcs  = '{32'h100, 32'h104, 32'h140, 32'h1100, 32'h3C, 32'hFFFF_FFFC, 32'h200, 32'h500};
    tgts = '{32'h200, 32'h300, 32'h400, 32'h0};
    rst_n = 1'b0; if_pc = 32'd0; ex_valid = 1'b0; ex_pc = 32'd0; ex_target = 32'd0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0; stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold lookup misses; first taken resolution mispredicts and trains.
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    cyc(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    // Saturate the counter, then a single not-taken keeps it predicting taken.
    repeat (3) cyc(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0);
    cyc(32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, 0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    // Mispredict held by a 3-cycle stall; wrong-path resolutions ignored.
    cyc(32'h140, 1, 32'h140, 1, 32'h400, 0, 32'h144, 1);
    repeat (3) cyc(32'h140, 1, 32'h100, 0, 32'h0, 0, 32'h0, 1);
    cyc(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    // Target mismatch on a predicted-taken branch retrains the BTB.
    cyc(32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h200, 0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    // Reset while redirecting.
    cyc(32'h100, 1, 32'h100, 1, 32'h500, 0, 32'h104, 0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1);
    reset_cyc(32'h100);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);
    cyc(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      p  = pcs[$urandom_range(0, 7)];
      ep = pcs[$urandom_range(0, 7)];
      tg = tgts[$urandom_range(0, 3)];
      v  = ($urandom_range(0, 2) != 0);
      tk = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        model_predict(ep, ptk, pg);
      end else begin
        ptk = ($urandom_range(0, 1) == 1);
        pg  = tgts[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 199) == 0) reset_cyc(p);
      else cyc(p, v, ep, tk, tg, ptk, pg, st);
    end

    @(negedge clk); #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
